// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Grant states, requester identities and the full-word byte select.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIfuRd,
    StLsuRd,
    StLsuWr
  } arb_state_t;

  typedef enum logic [1:0] {
    OwnNone,
    OwnIfu,
    OwnLsuRd,
    OwnLsuWr
  } arb_owner_t;

  localparam logic [3:0] SEL_WORD = 4'b1111;

  function automatic arb_state_t owner_to_state(arb_owner_t owner);
    case (owner)
      OwnIfu:   return StIfuRd;
      OwnLsuRd: return StLsuRd;
      OwnLsuWr: return StLsuWr;
      default:  return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait-age counter for the fetch requester.
// at_limit tells the arbiter that fetch has waited long enough to win outright.
module arb_age_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == Limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One transaction at a time, data side first, with an age-based fetch override.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_re,
  input  logic [XLEN-1:0] ifu_addr,
  output logic [XLEN-1:0] ifu_data,
  output logic            ifu_ack,
  input  logic            lsu_re,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [3:0]      lsu_sel,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_ack,
  output logic            mem_re,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_sel,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  arb_state_t      state_q, state_d;
  arb_owner_t      winner;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      sel_q, sel_d;
  logic            re_q, re_d;
  logic            we_q, we_d;
  logic            age_at_limit;
  logic            age_inc;
  logic            age_clr;

  // A starved fetch beats everything; otherwise store > load > fetch.
  always_comb begin
    winner = OwnNone;
    if (ifu_re && age_at_limit) begin
      winner = OwnIfu;
    end else if (lsu_we) begin
      winner = OwnLsuWr;
    end else if (lsu_re) begin
      winner = OwnLsuRd;
    end else if (ifu_re) begin
      winner = OwnIfu;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        state_d = owner_to_state(winner);
        unique case (winner)
          OwnIfu: begin
            addr_d = ifu_addr;
            sel_d  = SEL_WORD;
          end
          OwnLsuRd, OwnLsuWr: begin
            addr_d  = lsu_addr;
            sel_d   = lsu_sel;
            wdata_d = lsu_wdata;
          end
          default: ;
        endcase
      end
      // Granted: run to mem_ack even if the requester has gone away.
      default: begin
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
    endcase
    re_d = (state_d == StIfuRd) || (state_d == StLsuRd);
    we_d = (state_d == StLsuWr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      re_q    <= re_d;
      we_q    <= we_d;
    end
  end

  assign age_inc = ifu_re && (state_q != StIfuRd);
  assign age_clr = !ifu_re || ((state_q == StIdle) && (winner == OwnIfu));

  arb_age_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_age_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (age_inc),
    .clr      (age_clr),
    .at_limit (age_at_limit)
  );

  // An ack for a request that was withdrawn is swallowed here.
  assign ifu_ack = mem_ack && (state_q == StIfuRd) && ifu_re;
  assign lsu_ack = mem_ack && (((state_q == StLsuRd) && lsu_re) ||
                               ((state_q == StLsuWr) && lsu_we));

  assign ifu_data  = mem_rdata;
  assign lsu_rdata = mem_rdata;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_sel   = sel_q;
  assign mem_wdata = wdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between the instruction-fetch read channel and the load/store unit's read and write channels.
- Sits between the core (fetch stage, lsu) and the memory/c2c bus slave.
- Grants one transaction at a time and holds the grant until the slave acks.
- Data side has priority; an age counter prevents fetch starvation.

Parameters:
XLEN, 32, address/data width
STARVE_LIMIT, 4, consecutive cycles fetch may wait while denied before it wins the next arbitration (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
ifu_re  in  1  fetch read request, held until ifu_ack
ifu_addr  in  XLEN  fetch address
ifu_data  out  XLEN  fetch read data, valid with ifu_ack
ifu_ack  out  1  fetch transaction complete
lsu_re  in  1  data read request, held until lsu_ack
lsu_we  in  1  data write request, held until lsu_ack
lsu_addr  in  XLEN  data address
lsu_sel  in  4  byte select
lsu_wdata  in  XLEN  store data
lsu_rdata  out  XLEN  load data, valid with lsu_ack
lsu_ack  out  1  data transaction complete
mem_re  out  1  shared-port read strobe
mem_we  out  1  shared-port write strobe
mem_addr  out  XLEN  shared-port address
mem_sel  out  4  shared-port byte select
mem_wdata  out  XLEN  shared-port write data
mem_rdata  in  XLEN  shared-port read data
mem_ack  in  1  shared-port completion

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. Reset (any state, including mid-transaction) -> IDLE next edge.
- Reset values: mem_re=0, mem_we=0, mem_addr=0, mem_sel=0, mem_wdata=0, age counter=0. ifu_ack and lsu_ack are 0 whenever state is IDLE.
- Arbitration happens only in IDLE, sampled at the clock edge. Priority order:
  - (a) ifu_re when age==STARVE_LIMIT
  - (b) lsu_we
  - (c) lsu_re
  - (d) ifu_re
- lsu_re and lsu_we asserted together: write wins. The read is not performed.
- Grant registers mem_addr/mem_sel/mem_wdata from the winner and sets the state.
  - Fetch uses mem_sel=4'b1111, mem_wdata unchanged.
  - mem_re=1 in IFU_RD/LSU_RD; mem_we=1 in LSU_WR; strobes are registered.
- Latency: request seen in IDLE at edge N -> strobe high from N+1 -> ack cycle M -> back in IDLE at M+1, strobe low. Minimum 2 cycles per transaction plus slave wait states. One bubble cycle (IDLE) always separates transactions.
- Ack forwarding: in a granted state, the owner's ack = mem_ack & owner's request still high (combinational). Read data passes through combinationally: ifu_data=mem_rdata, lsu_rdata=mem_rdata.
- Dropped request: if the requester drops its request before mem_ack, the transaction still runs to mem_ack (no abort). The ack is discarded, then the FSM goes to IDLE.
- mem_ack while in IDLE is ignored.
- Latched address/data are not updated while granted; requester input changes mid-transaction have no effect.
- Age counter:
  - Increments each cycle ifu_re=1 and fetch is not the owner, saturating at STARVE_LIMIT.
  - Clears when fetch is granted, or when ifu_re=0.

Decomposition:
- mem_arb_pkg: state enum (arb_state_t), owner encoding, SEL_WORD constant.
- One sub-module, arb_age_counter: saturating counter with inc/clr inputs and an at_limit output, parameterised by STARVE_LIMIT.
- Everything else lives in mem_bus_arbiter.

Test Plan:
1. Reset, then ifu_re=1, ifu_addr=0x100, slave acks on the second strobe cycle -> mem_re high from cycle 1, mem_addr=0x100, mem_sel=0xF. ifu_ack pulses one cycle with ifu_data=mem_rdata=0xDEADBEEF. IDLE on the next cycle.
2. lsu_we=1 (addr 0x2000, sel 0x3, wdata 0x1234) and ifu_re=1 in the same cycle -> write granted first with mem_we=1 and mem_wdata=0x1234. Fetch is granted after the ack plus the bubble cycle.
3. lsu_re held continuously with repeated requests while ifu_re is held, slave ack latency 1, STARVE_LIMIT=4 -> fetch is granted no later than the arbitration after age reaches 4. Age returns to 0 after the grant.
4. lsu_re=1 and lsu_we=1 together -> only mem_we asserts; lsu_ack pulses once; mem_re stays 0.
5. Assert reset while in LSU_RD before mem_ack -> next cycle state is IDLE and mem_re=0. A later mem_ack produces no lsu_ack.
6. Drop ifu_re after the grant, before mem_ack -> mem_re stays high until mem_ack, ifu_ack stays 0, and the FSM returns to IDLE.
